// File: rtl/vga_frame_scaler_pkg.sv
// Shared framebuffer geometry defaults and RGB111 colour constants ({R,G,B}),
// also used by the buffer RAM and the display top level.
package vga_frame_scaler_pkg;

  localparam int IMG_W_DEF    = 16;
  localparam int IMG_H_DEF    = 12;
  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 3;
  localparam int PW_DEF       = 12;
  localparam int MAX_LOG2_DEF = 6;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_WHITE = 3'b111;

  function automatic logic [2:0] clamp_log2(input logic [2:0] req, input logic [2:0] max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/vga_frame_scaler_axis.sv
// One axis of the scaler: sub-pixel counter plus block index; outputs show post-step
// state in the same cycle (zero latency), no backpressure -- advances only on i_step.
module scale_axis_counter #(
  parameter int IW = 4,
  parameter int LW = 3,
  parameter int SW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_step,
  input  logic          i_start,
  input  logic          i_clr,
  input  logic [IW-1:0] i_limit,
  input  logic [LW-1:0] i_log2,
  output logic [IW-1:0] o_idx,
  output logic          o_active,
  output logic          o_wrap
);

  logic [SW-1:0] r_sub;
  logic [IW-1:0] r_idx;
  logic          r_active;

  logic [SW-1:0] w_sub_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic          w_act_nxt;
  logic [SW:0]   w_edge;
  logic [SW:0]   w_edge_m1;
  logic [SW-1:0] w_mask;

  assign w_edge    = (SW+1)'(1) << i_log2;
  assign w_edge_m1 = w_edge - (SW+1)'(1);
  assign w_mask    = w_edge_m1[SW-1:0];

  // Start beats clear so a window anchored at position 0 reopens on every line/frame.
  always_comb begin
    w_sub_nxt = r_sub;
    w_idx_nxt = r_idx;
    w_act_nxt = r_active;
    o_wrap    = 1'b0;
    if (i_step) begin
      if (i_start) begin
        w_sub_nxt = '0;
        w_idx_nxt = '0;
        w_act_nxt = 1'b1;
      end else if (i_clr) begin
        w_act_nxt = 1'b0;
      end else if (r_active) begin
        if (r_sub == w_mask) begin
          o_wrap    = 1'b1;
          w_sub_nxt = '0;
          if (r_idx == i_limit) begin
            w_act_nxt = 1'b0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_sub_nxt = r_sub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sub    <= '0;
      r_idx    <= '0;
      r_active <= 1'b0;
    end else begin
      r_sub    <= w_sub_nxt;
      r_idx    <= w_idx_nxt;
      r_active <= w_act_nxt;
    end
  end

  assign o_idx    = w_idx_nxt;
  assign o_active = w_act_nxt;

endmodule

// File: rtl/vga_frame_scaler.sv
// Maps VGA driver position to framebuffer address with 2^s pixel replication and offset;
// latency posX step -> pixel is 1+RD_LAT clocks, no backpressure (follows the driver).
module vga_frame_scaler
  import vga_frame_scaler_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int PW       = PW_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF,
  parameter int RD_LAT   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [PW-1:0] i_pos_x,
  input  logic [PW-1:0] i_pos_y,
  input  logic [2:0]    i_scale_log2,
  input  logic [PW-1:0] i_off_x,
  input  logic [PW-1:0] i_off_y,
  input  logic [DW-1:0] i_border,
  input  logic [DW-1:0] i_mem_data,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_pixel,
  output logic          o_in_img
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [PW-1:0]     r_prev_x;
  logic [PW-1:0]     r_off_x;
  logic [PW-1:0]     r_off_y;
  logic [2:0]        r_scale;
  logic              r_cfg_vld;
  logic [AW-1:0]     r_row_base;
  logic [AW-1:0]     r_mem_addr;
  logic              r_win;
  logic [RD_LAT-1:0] r_win_dly;

  logic          w_step;
  logic          w_line;
  logic          w_frame;
  logic [2:0]    w_scale;
  logic [PW-1:0] w_off_x;
  logic [PW-1:0] w_off_y;
  logic          w_cfg_vld;
  logic          w_x_start;
  logic          w_y_start;
  logic [XW-1:0] w_col;
  logic [YW-1:0] w_row_unused;
  logic          w_x_act;
  logic          w_y_act;
  logic          w_x_wrap_unused;
  logic          w_y_wrap;
  logic [AW-1:0] w_row_base_nxt;
  logic [AW-1:0] w_addr;
  logic          w_win;
  logic          w_flag;

  assign w_step  = (i_pos_x != r_prev_x);
  assign w_line  = w_step && (i_pos_x == '0);
  assign w_frame = w_line && (i_pos_y == '0);

  // Configuration latched at frame start is used by that same step.
  assign w_scale   = w_frame ? clamp_log2(i_scale_log2, 3'(MAX_LOG2)) : r_scale;
  assign w_off_x   = w_frame ? i_off_x : r_off_x;
  assign w_off_y   = w_frame ? i_off_y : r_off_y;
  assign w_cfg_vld = w_frame || r_cfg_vld;
  assign w_x_start = w_cfg_vld && (i_pos_x == w_off_x);
  assign w_y_start = w_cfg_vld && (i_pos_y == w_off_y);

  scale_axis_counter #(.IW(XW), .LW(3), .SW(MAX_LOG2)) u_axis_x (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_step   (w_step),
    .i_start  (w_x_start),
    .i_clr    (i_pos_x == '0),
    .i_limit  (XW'(IMG_W - 1)),
    .i_log2   (w_scale),
    .o_idx    (w_col),
    .o_active (w_x_act),
    .o_wrap   (w_x_wrap_unused)
  );

  scale_axis_counter #(.IW(YW), .LW(3), .SW(MAX_LOG2)) u_axis_y (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_step   (w_line),
    .i_start  (w_y_start),
    .i_clr    (w_frame),
    .i_limit  (YW'(IMG_H - 1)),
    .i_log2   (w_scale),
    .o_idx    (w_row_unused),
    .o_active (w_y_act),
    .o_wrap   (w_y_wrap)
  );

  // Row base advances by one image line per row wrap instead of row*IMG_W.
  always_comb begin
    w_row_base_nxt = r_row_base;
    if (w_line && w_y_start) begin
      w_row_base_nxt = '0;
    end else if (w_y_wrap) begin
      w_row_base_nxt = r_row_base + AW'(IMG_W);
    end
  end

  assign w_addr = w_row_base_nxt + {{(AW-XW){1'b0}}, w_col};
  assign w_win  = w_x_act && w_y_act;

  always_ff @(posedge i_clk) begin
    r_prev_x <= i_pos_x;
    if (!i_rst) begin
      r_scale    <= clamp_log2(i_scale_log2, 3'(MAX_LOG2));
      r_off_x    <= '0;
      r_off_y    <= '0;
      r_cfg_vld  <= 1'b0;
      r_row_base <= '0;
      r_mem_addr <= '0;
      r_win      <= 1'b0;
      r_win_dly  <= '0;
    end else begin
      r_scale    <= w_scale;
      r_off_x    <= w_off_x;
      r_off_y    <= w_off_y;
      r_cfg_vld  <= w_cfg_vld;
      r_row_base <= w_row_base_nxt;
      if (w_win) begin
        r_mem_addr <= w_addr;
      end
      r_win        <= w_win;
      r_win_dly[0] <= r_win;
      for (int i = 1; i < RD_LAT; i++) begin
        r_win_dly[i] <= r_win_dly[i-1];
      end
    end
  end

  assign w_flag     = r_win_dly[RD_LAT-1];
  assign o_mem_addr = r_mem_addr;
  // Until a frame start revalidates the configuration, drive black rather than border.
  assign o_pixel    = !r_cfg_vld ? '0 : (w_flag ? i_mem_data : i_border);
  assign o_in_img   = w_flag;

endmodule

// File: tb/tb_vga_frame_scaler.sv
// Directed bench: RD_LAT=1 instance (A) and RD_LAT=3 instance (B) on shared position inputs,
// each backed by a small registered-read RAM model holding mem[a] = (a+5) mod 8.
module tb_vga_frame_scaler;

  logic        clk;
  logic        rst;
  logic [11:0] pos_x, pos_y, off_x, off_y;
  logic [2:0]  scale_a, scale_b, border;
  logic [2:0]  mem_data_a, mem_data_b;
  logic [7:0]  addr_a, addr_b;
  logic [2:0]  pix_a, pix_b;
  logic        img_a, img_b;
  logic [2:0]  mem [256];
  logic [2:0]  b_p1, b_p2, b_p3;
  int          n_chk;
  int          n_err;

  vga_frame_scaler #(.RD_LAT(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_pos_x(pos_x), .i_pos_y(pos_y),
    .i_scale_log2(scale_a), .i_off_x(off_x), .i_off_y(off_y), .i_border(border),
    .i_mem_data(mem_data_a), .o_mem_addr(addr_a), .o_pixel(pix_a), .o_in_img(img_a)
  );

  vga_frame_scaler #(.RD_LAT(3)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_pos_x(pos_x), .i_pos_y(pos_y),
    .i_scale_log2(scale_b), .i_off_x(off_x), .i_off_y(off_y), .i_border(border),
    .i_mem_data(mem_data_b), .o_mem_addr(addr_b), .o_pixel(pix_b), .o_in_img(img_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_data_a <= mem[addr_a];
    b_p1 <= mem[addr_b];
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign mem_data_b = b_p3;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int x, input int y);
    pos_x = 12'(x);
    pos_y = 12'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic skip_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      step_to(0, y);
      step_to(1, y);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 3'((i + 5) % 8);
    rst = 1'b0; pos_x = 12'd1023; pos_y = 12'd767;
    scale_a = 3'd6; scale_b = 3'd7; off_x = '0; off_y = '0; border = 3'b000;
    hold(2);
    chk("reset_addr", addr_a, 0);
    chk("reset_pixel", pix_a, 0);
    chk("reset_in_img", img_a, 0);
    rst = 1'b1;

    // Frame 1: full screen, 64-px blocks (B requests 7, clamped to 6).
    step_to(0, 0);
    chk("fs_addr_0_0", addr_a, 0);
    hold(1);
    chk("fs_pixel_0_0", pix_a, 5);
    chk("fs_in_img_0_0", img_a, 1);
    for (int x = 1; x <= 63; x++) step_to(x, 0);
    chk("fs_addr_63_0", addr_a, 0);
    step_to(64, 0);
    chk("fs_addr_64_0", addr_a, 1);
    chk("clamp_addr_64_0", addr_b, 1);
    hold(5);
    chk("stall_addr", addr_a, 1);
    chk("stall_pixel", pix_a, 6);
    for (int x = 65; x <= 127; x++) step_to(x, 0);
    chk("resume_addr_127", addr_a, 1);
    step_to(128, 0);
    chk("resume_addr_128", addr_a, 2);
    step_to(129, 0);
    chk("lat1_pixel_2clk", pix_a, 7);
    step_to(130, 0);
    chk("lat3_pixel_3clk", pix_b, 6);
    step_to(131, 0);
    chk("lat3_pixel_4clk", pix_b, 7);
    chk("lat3_in_img", img_b, 1);
    for (int x = 132; x <= 1023; x++) step_to(x, 0);
    skip_lines(1, 63);
    step_to(0, 64);
    chk("fs_addr_0_64", addr_a, 16);
    step_to(1, 64);
    skip_lines(65, 299);
    scale_a = 3'd5;
    scale_b = 3'd5;
    skip_lines(300, 766);
    for (int x = 0; x <= 1023; x++) step_to(x, 767);
    chk("fs_addr_1023_767", addr_a, 191);
    chk("clamp_addr_1023_767", addr_b, 191);
    hold(1);
    chk("fs_pixel_1023_767", pix_a, 4);
    chk("fs_in_img_1023_767", img_a, 1);

    // Frame 2: scale 5 now latched at frame start.
    step_to(0, 0);
    chk("s5_addr_0_0", addr_a, 0);
    for (int x = 1; x <= 31; x++) step_to(x, 0);
    chk("s5_addr_31_0", addr_a, 0);
    step_to(32, 0);
    chk("s5_addr_32_0", addr_a, 1);

    // Frame 3: centred 512x384 window with blue border.
    off_x = 12'd256; off_y = 12'd192; border = 3'b001;
    step_to(0, 0);
    step_to(1, 0);
    skip_lines(1, 191);
    for (int x = 0; x <= 255; x++) step_to(x, 192);
    chk("ctr_addr_hold_255", addr_a, 1);
    hold(1);
    chk("ctr_pixel_255", pix_a, 1);
    chk("ctr_in_img_255", img_a, 0);
    step_to(256, 192);
    chk("ctr_addr_256", addr_a, 0);
    hold(1);
    chk("ctr_pixel_256", pix_a, 5);
    chk("ctr_in_img_256", img_a, 1);
    for (int x = 257; x <= 767; x++) step_to(x, 192);
    chk("ctr_addr_767", addr_a, 15);
    step_to(768, 192);
    chk("ctr_addr_hold_768", addr_a, 15);
    hold(1);
    chk("ctr_pixel_768", pix_a, 1);
    chk("ctr_in_img_768", img_a, 0);

    // Frame 4: full screen again, reset at posX=500.
    off_x = '0; off_y = '0; scale_a = 3'd6; scale_b = 3'd6; border = 3'b010;
    step_to(0, 0);
    for (int x = 1; x <= 500; x++) step_to(x, 0);
    chk("pre_rst_addr_500", addr_a, 7);
    rst = 1'b0;
    hold(1);
    chk("midrst_addr", addr_a, 0);
    chk("midrst_pixel", pix_a, 0);
    chk("midrst_in_img", img_a, 0);
    rst = 1'b1;
    step_to(501, 0);
    hold(1);
    chk("postrst_pixel", pix_a, 0);
    chk("postrst_in_img", img_a, 0);
    step_to(0, 1);
    hold(1);
    chk("postrst_line_in_img", img_a, 0);
    chk("postrst_line_addr", addr_a, 0);
    step_to(1, 1);
    step_to(0, 0);
    hold(1);
    chk("refs_pixel_0_0", pix_a, 5);
    chk("refs_in_img_0_0", img_a, 1);
    for (int x = 1; x <= 64; x++) step_to(x, 0);
    chk("refs_addr_64_0", addr_a, 1);
    hold(1);
    chk("refs_pixel_64_0", pix_a, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
